// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared widths and stage-1 register type for the four-operand CSA adder
//
// Contents:
//   CSA_W       default operand width of the adder slice
//   res_w()     result width for a given operand width (two growth bits)
//   RES_W       result width at the default operand width
//   csa_pair_t  stage-1 carry-save register: sum vector, carry vector, row carry-out
package csa_pkg;

    localparam int CSA_W = 8;

    // Four W-bit operands plus a unit carry-in peak at 4*(2^W-1)+1, which fits in W+2 bits.
    function automatic int res_w(input int w);
        return w + 2;
    endfunction

    localparam int RES_W = res_w(CSA_W);

    // s at weight i, cv at weight i+1, co_msb at weight W.
    typedef struct packed {
        logic [CSA_W-1:0] s;
        logic [CSA_W-1:0] cv;
        logic             co_msb;
    } csa_pair_t;

endpackage

// File: rtl/compressor4to2.sv
// rtl/compressor4to2.sv - single-bit 4:2 compressor cell built from two full adders
//
// Ports:
//   x1..x4  input   four bits of equal weight i
//   cin     input   lateral carry from the neighbouring cell, weight i
//   sum     output  weight i
//   carry   output  weight i+1
//   cout    output  weight i+1, lateral carry to the next cell
module compressor4to2 (
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic x4,
    input  logic cin,
    output logic sum,
    output logic carry,
    output logic cout
);

    logic s_first;

    // cout depends only on x1..x3, so the lateral chain never ripples through cin.
    assign s_first = x1 ^ x2 ^ x3;
    assign cout    = (x1 & x2) | (x1 & x3) | (x2 & x3);

    assign sum     = s_first ^ x4 ^ cin;
    assign carry   = (s_first & x4) | (s_first & cin) | (x4 & cin);

endmodule

// File: rtl/csa_row4to2.sv
// rtl/csa_row4to2.sv - combinational row of W compressor4to2 cells with lateral carry chain
//
// Ports:
//   op_a..op_d  input   W-bit operands
//   op_cin      input   carry-in at weight 0, enters cell 0 lateral input
//   s           output  W-bit sum vector, bit i at weight i
//   cv          output  W-bit carry vector, bit i at weight i+1
//   co_msb      output  lateral carry out of cell W-1, weight W
module csa_row4to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] op_c,
    input  logic [W-1:0] op_d,
    input  logic         op_cin,
    output logic [W-1:0] s,
    output logic [W-1:0] cv,
    output logic         co_msb
);

    // chain[i] feeds cell i; chain[i+1] is cell i's cout.
    logic [W:0] chain;

    assign chain[0] = op_cin;
    assign co_msb   = chain[W];

    for (genvar i = 0; i < W; i++) begin : g_cell
        compressor4to2 u_cell (
            .x1    (op_a[i]),
            .x2    (op_b[i]),
            .x3    (op_c[i]),
            .x4    (op_d[i]),
            .cin   (chain[i]),
            .sum   (s[i]),
            .carry (cv[i]),
            .cout  (chain[i+1])
        );
    end

endmodule

// File: rtl/csa4_pipe_adder.sv
// rtl/csa4_pipe_adder.sv - two-stage pipelined adder of four W-bit operands plus carry-in
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand beat handshake
//   op_a..op_d, op_cin  unsigned operands and unit carry-in
//   out_valid, out_ready result handshake
//   result              exact W+2 bit sum
//
// Stage 1 holds the compressor row output in carry-save form; stage 2 holds the
// resolved sum. Each stage advances when its downstream slot is empty or draining,
// so the pipe streams one beat per cycle and holds two beats under backpressure.
// The stage-1 register uses csa_pair_t, whose field width is csa_pkg::CSA_W, so W
// is expected to match CSA_W.
module csa4_pipe_adder
    import csa_pkg::*;
#(
    parameter int W = CSA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] op_c,
    input  logic [W-1:0] op_d,
    input  logic         op_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] result
);

    logic [W-1:0] row_s;
    logic [W-1:0] row_cv;
    logic         row_co;

    csa_pair_t    s1_d;
    csa_pair_t    s1_q;
    logic         s1_valid;
    logic         s2_valid;
    logic         s1_load;
    logic         s2_load;
    logic [W+1:0] cpa_sum;

    csa_row4to2 #(.W(W)) u_row (
        .op_a   (op_a),
        .op_b   (op_b),
        .op_c   (op_c),
        .op_d   (op_d),
        .op_cin (op_cin),
        .s      (row_s),
        .cv     (row_cv),
        .co_msb (row_co)
    );

    always_comb begin
        s1_d        = '0;
        s1_d.s      = row_s;
        s1_d.cv     = row_cv;
        s1_d.co_msb = row_co;
    end

    // in_ready depends on out_ready and pipe occupancy only, never on in_valid.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    // Carry-propagate resolution of the carry-save pair at full result width.
    assign cpa_sum = {2'b00, s1_q.s}
                   + {1'b0, s1_q.cv, 1'b0}
                   + {1'b0, s1_q.co_msb, {W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result <= cpa_sum;
            end
        end
    end

endmodule

// File: tb/tb_csa4_pipe_adder.sv
// tb/tb_csa4_pipe_adder.sv - self-checking bench for csa4_pipe_adder at W=8
module tb_csa4_pipe_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] op_c = '0;
    logic [W-1:0] op_d = '0;
    logic         op_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W+1:0] result;

    int checks = 0;
    int failures = 0;

    // Reference: every accepted beat's arithmetic sum, oldest first.
    logic [W+1:0] exp_q[$];
    logic         in_fire;
    logic         out_fire;

    always #5 clk = ~clk;

    csa4_pipe_adder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .op_d      (op_d),
        .op_cin    (op_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    function automatic logic [W+1:0] ref_sum(input logic [W-1:0] a, b, c, d, input logic ci);
        int s;
        s = int'(a) + int'(b) + int'(c) + int'(d) + int'(ci);
        return s[W+1:0];
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, b, c, d, input logic ci, input logic rdy);
        in_valid  = v;
        op_a      = a;
        op_b      = b;
        op_c      = c;
        op_d      = d;
        op_cin    = ci;
        out_ready = rdy;
        #1;
    endtask

    // Record the transfers about to happen at the next edge, then advance to 1 ns after it.
    task automatic tick();
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (out_fire && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_fire) exp_q.push_back(ref_sum(op_a, op_b, op_c, op_d, op_cin));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (result !== '0) begin failures++; $display("FAIL reset_result got %h exp 000", result); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        exp_q.delete();
    endtask

    task automatic test_max_operands();
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL max_early_valid got %b exp 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== 10'h3FD) begin
            failures++; $display("FAIL max_result got v=%b %h exp v=1 3fd", out_valid, result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL max_single_pulse got %b exp 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] va[4] = '{8'h01, 8'h80, 8'h00, 8'h0F};
        logic [W-1:0] vb[4] = '{8'h02, 8'h80, 8'h00, 8'hF0};
        logic [W-1:0] vc[4] = '{8'h03, 8'h80, 8'h00, 8'h55};
        logic [W-1:0] vd[4] = '{8'h04, 8'h80, 8'h00, 8'hAA};
        logic         vi[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int           ex[4] = '{10, 513, 0, 510};
        for (int j = 0; j < 6; j++) begin
            if (j < 4) drive(1'b1, va[j], vb[j], vc[j], vd[j], vi[j], 1'b1);
            else       drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cycle %0d got %b exp 1", j, in_ready); end
            tick();
            if (j >= 1 && j <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || result !== ex[j-1][W+1:0]) begin
                    failures++; $display("FAIL stream_result %0d got v=%b %0d exp v=1 %0d", j-1, out_valid, result, ex[j-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int           accepted = 0;
        logic [W+1:0] first;
        logic [W+1:0] second;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if (in_valid && in_ready) accepted++;
            tick();
            if (accepted == 1 && exp_q.size() == 1) first = exp_q[0];
            if (j >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || result !== first) begin
                    failures++; $display("FAIL bp_hold cycle %0d got v=%b %h exp v=1 %h", j, out_valid, result, first);
                end
            end
        end
        checks++;
        if (accepted != 2) begin failures++; $display("FAIL bp_accepted got %0d exp 2", accepted); end
        drive(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        second = exp_q[1];
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== second) begin
            failures++; $display("FAIL bp_drain got v=%b %h exp v=1 %h", out_valid, result, second);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_end got %b exp 0", out_valid); end
    endtask

    task automatic test_ready_on_full();
        logic [W+1:0] b1;
        logic [W+1:0] b2;
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            tick();
        end
        b1 = exp_q[1];
        drive(1'b1, 8'h9C, 8'h3A, 8'hE1, 8'h07, 1'b1, 1'b1);
        b2 = ref_sum(8'h9C, 8'h3A, 8'hE1, 8'h07, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rof_in_ready got %b exp 1", in_ready); end
        tick();
        checks++;
        if (!(in_fire && out_fire)) begin failures++; $display("FAIL rof_same_cycle got in=%b out=%b exp in=1 out=1", in_fire, out_fire); end
        checks++;
        if (out_valid !== 1'b1 || result !== b1) begin
            failures++; $display("FAIL rof_next got v=%b %h exp v=1 %h", out_valid, result, b1);
        end
        drive(1'b1, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rof_refull got %b exp 0", in_ready); end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || result !== b2) begin
            failures++; $display("FAIL rof_third got v=%b %h exp v=1 %h", out_valid, result, b2);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0) begin
            failures++; $display("FAIL rst_async got v=%b %h exp v=0 000", out_valid, result);
        end
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
        for (int j = 0; j < 4; j++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale cycle %0d got %b exp 0", j, out_valid); end
        end
    endtask

    task automatic test_random_sweep();
        logic         held = 1'b0;
        logic [W+1:0] held_val = '0;
        for (int j = 0; j < 400; j++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (in_ready !== (exp_q.size() < 2 || out_ready)) begin
                failures++; $display("FAIL rand_in_ready cycle %0d got %b exp %b", j, in_ready, (exp_q.size() < 2 || out_ready));
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || result !== held_val) begin
                    failures++; $display("FAIL rand_stall cycle %0d got v=%b %h exp v=1 %h", j, out_valid, result, held_val);
                end
            end
            if (exp_q.size() == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL rand_phantom cycle %0d got %b exp 0", j, out_valid); end
            end else if (out_valid && out_ready) begin
                checks++;
                if (result !== exp_q[0]) begin
                    failures++; $display("FAIL rand_result cycle %0d got %h exp %h", j, result, exp_q[0]);
                end
            end
            held     = out_valid && !out_ready;
            held_val = result;
            tick();
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
            if (out_valid && exp_q.size() > 0) begin
                checks++;
                if (result !== exp_q[0]) begin failures++; $display("FAIL rand_tail got %h exp %h", result, exp_q[0]); end
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL rand_drained got v=%b left=%0d exp v=0 left=0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_streaming();
        test_backpressure();
        test_ready_on_full();
        test_reset_midflight();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
